// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported instruction/data memory between the fetch (IF)
// and load/store (DM) requesters. One access is outstanding at a time; the
// read data (or write acknowledge) is routed back to the owner MEM_LAT
// cycles after issue. DM has priority, but IF is guaranteed a grant after
// IF_STARVE_MAX consecutive DM grants made while IF was waiting.
module unified_mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 2,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [2:0] LAT_C        = 3'(MEM_LAT);
    localparam logic [2:0] STARVE_MAX_C = 3'(IF_STARVE_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic       owner;       // 0 = IF, 1 = DM
    logic [2:0] cnt;         // cycles left until read data is valid
    logic [2:0] starve_cnt;  // DM grants taken while IF was waiting

    logic complete;
    logic slot_free;
    logic if_pick;

    // Slot availability, arbitration and memory-side mux. Grants are gated by
    // reset so nothing leaks out while the block is held in reset.
    always_comb begin
        complete  = (state == BUSY) && (cnt == 3'd1);
        slot_free = (state == IDLE) || complete;
        // IF wins when it is the sole requester or has been starved long enough
        if_pick   = if_req && (!dm_req || (starve_cnt == STARVE_MAX_C));

        if_gnt    = reset && slot_free && if_pick;
        dm_gnt    = reset && slot_free && dm_req && !if_pick;

        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_be    = '1;
            mem_addr  = if_addr;
        end
    end

    // Return path: one-cycle rvalid to the owner on the completion cycle;
    // the non-owner sees zero data.
    always_comb begin
        if_rvalid = reset && complete && !owner;
        dm_rvalid = reset && complete && owner;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

    // Outstanding-access tracker and IF starvation counter. An issue on the
    // completion cycle simply reloads the tracker (back-to-back throughput).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= 3'd0;
            starve_cnt <= 3'd0;
        end else begin
            if (mem_en) begin
                state <= BUSY;
                owner <= dm_gnt;
                cnt   <= LAT_C;
            end else if (complete) begin
                state <= IDLE;
                cnt   <= 3'd0;
            end else if (state == BUSY) begin
                cnt   <= cnt - 3'd1;
            end

            if (if_gnt) begin
                starve_cnt <= 3'd0;
            end else if (dm_gnt && if_req && (starve_cnt < STARVE_MAX_C)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. Three instances share clock and
// reset: g_dut[0] MEM_LAT=2, g_dut[1] MEM_LAT=1, g_dut[2] MEM_LAT=3, all with
// IF_STARVE_MAX=4. Each has a small memory model returning mem_fn(addr)
// MEM_LAT cycles after the address was issued.
module tb_unified_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic        if_gnt    [N];
    logic        if_rvalid [N];
    logic [31:0] if_rdata  [N];
    logic        dm_req    [N];
    logic        dm_we     [N];
    logic [3:0]  dm_be     [N];
    logic [31:0] dm_addr   [N];
    logic [31:0] dm_wdata  [N];
    logic        dm_gnt    [N];
    logic        dm_rvalid [N];
    logic [31:0] dm_rdata  [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [3:0]  mem_be    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'hCAFE_0000);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);

        unified_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .IF_STARVE_MAX(4)
        ) dut (
            .clk(clk), .reset(reset),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_be(dm_be[g]),
            .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]), .dm_gnt(dm_gnt[g]),
            .dm_rvalid(dm_rvalid[g]), .dm_rdata(dm_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );

        // memory model: address delay line of depth LAT
        logic [31:0] dl [LAT];
        always @(posedge clk) begin
            dl[0] <= mem_addr[g];
            for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
        end
        assign mem_rdata[g] = mem_fn(dl[LAT-1]);

        // requests must be held until granted
        logic pend_if = 1'b0;
        logic pend_dm = 1'b0;
        always @(posedge clk) begin
            if (reset && pend_if) assert (if_req[g]) else $error("protocol: if_req dropped before grant");
            if (reset && pend_dm) assert (dm_req[g]) else $error("protocol: dm_req dropped before grant");
            pend_if <= reset && if_req[g] && !if_gnt[g];
            pend_dm <= reset && dm_req[g] && !dm_gnt[g];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        for (int k = 0; k < N; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_be[k] = '0;
            dm_addr[k] = '0; dm_wdata[k] = '0;
        end
    endtask

    task automatic do_reset;
        tick;
        clear_inputs;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int last;

        // ---- 1: outputs gated in reset, DM wins on release ----
        reset = 1'b0;
        clear_inputs;
        if_req[0] = 1'b1; if_addr[0] = 32'h80;
        dm_req[0] = 1'b1; dm_addr[0] = 32'h200; dm_be[0] = 4'hF;
        tick;
        sample;
        check("rst_if_gnt",    if_gnt[0],    0);
        check("rst_dm_gnt",    dm_gnt[0],    0);
        check("rst_mem_en",    mem_en[0],    0);
        check("rst_mem_addr",  mem_addr[0],  0);
        check("rst_mem_be",    mem_be[0],    0);
        check("rst_rvalid",    {if_rvalid[0], dm_rvalid[0]}, 0);
        check("rst_rdata",     {if_rdata[0], dm_rdata[0]},  0);
        tick;
        reset = 1'b1;
        sample;
        check("rel_dm_gnt",    dm_gnt[0],    1);
        check("rel_if_gnt",    if_gnt[0],    0);
        check("rel_mem_en",    mem_en[0],    1);
        check("rel_mem_addr",  mem_addr[0],  32'h200);
        do_reset;

        // ---- 2: single IF read, MEM_LAT=2 ----
        if_req[0] = 1'b1; if_addr[0] = 32'h40;
        sample;
        check("t2_if_gnt",     if_gnt[0],    1);
        check("t2_mem_en",     mem_en[0],    1);
        check("t2_mem_addr",   mem_addr[0],  32'h40);
        check("t2_mem_we",     mem_we[0],    0);
        check("t2_mem_be",     mem_be[0],    4'hF);
        tick;
        if_req[0] = 1'b0;
        sample;
        check("t2_rv_t1",      {if_rvalid[0], dm_rvalid[0]}, 0);
        check("t2_gnt_t1",     {if_gnt[0], dm_gnt[0]}, 0);
        tick;
        sample;
        check("t2_if_rvalid",  if_rvalid[0], 1);
        check("t2_if_rdata",   if_rdata[0],  32'hDEAD_BEEF);
        check("t2_dm_rvalid",  dm_rvalid[0], 0);
        check("t2_dm_rdata",   dm_rdata[0],  0);
        tick;
        sample;
        check("t2_rv_t3",      if_rvalid[0], 0);
        do_reset;

        // ---- 3: DM write, MEM_LAT=2 ----
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_be[0] = 4'b0011;
        dm_addr[0] = 32'h100; dm_wdata[0] = 32'h1234_5678;
        sample;
        check("t3_dm_gnt",     dm_gnt[0],    1);
        check("t3_mem_we",     mem_we[0],    1);
        check("t3_mem_be",     mem_be[0],    4'b0011);
        check("t3_mem_wdata",  mem_wdata[0], 32'h1234_5678);
        check("t3_mem_addr",   mem_addr[0],  32'h100);
        tick;
        clear_inputs;
        sample;
        check("t3_rv_t1",      dm_rvalid[0], 0);
        tick;
        sample;
        check("t3_dm_rvalid",  dm_rvalid[0], 1);
        check("t3_if_rvalid",  if_rvalid[0], 0);
        tick;
        sample;
        check("t3_rv_t3",      dm_rvalid[0], 0);
        do_reset;

        // ---- 4: both requesting continuously, starvation bound 4 ----
        if_req[0] = 1'b1; if_addr[0] = 32'h80;
        dm_req[0] = 1'b1; dm_addr[0] = 32'h200; dm_be[0] = 4'hF;
        n = 0;
        last = -1;
        for (int c = 0; c < 20; c++) begin
            sample;
            if (if_gnt[0] || dm_gnt[0]) begin
                check("t4_single_gnt", if_gnt[0] & dm_gnt[0], 0);
                check("t4_seq_is_if",  if_gnt[0], (n % 5) == 4);
                if (last >= 0) check("t4_gap", 64'(c - last), 2);
                last = c;
                n++;
            end
            tick;
        end
        check("t4_grant_count", 64'(n), 10);
        do_reset;

        // ---- 5: MEM_LAT=1, eight back-to-back IF reads ----
        for (int i = 0; i < 8; i++) begin
            if_req[1] = 1'b1; if_addr[1] = 32'h1000 + 32'(4 * i);
            sample;
            check("t5_if_gnt",   if_gnt[1],   1);
            check("t5_mem_addr", mem_addr[1], 32'h1000 + 32'(4 * i));
            if (i > 0) begin
                check("t5_rvalid", if_rvalid[1], 1);
                check("t5_rdata",  if_rdata[1],  mem_fn(32'h1000 + 32'(4 * (i - 1))));
            end else begin
                check("t5_rvalid0", if_rvalid[1], 0);
            end
            tick;
        end
        if_req[1] = 1'b0;
        sample;
        check("t5_last_rvalid", if_rvalid[1], 1);
        check("t5_last_rdata",  if_rdata[1],  mem_fn(32'h101C));
        check("t5_no_gnt",      if_gnt[1],    0);
        tick;
        sample;
        check("t5_idle_rvalid", if_rvalid[1], 0);
        do_reset;

        // ---- 6: MEM_LAT=3, reset mid-access abandons it ----
        dm_req[2] = 1'b1; dm_addr[2] = 32'h300; dm_be[2] = 4'hF;
        sample;
        check("t6_dm_gnt",     dm_gnt[2],    1);
        tick;
        dm_req[2] = 1'b0;
        reset = 1'b0;
        sample;
        check("t6_rv_t1",      dm_rvalid[2], 0);
        check("t6_en_t1",      mem_en[2],    0);
        for (int j = 2; j <= 4; j++) begin
            tick;
            sample;
            check("t6_rv_in_rst", dm_rvalid[2], 0);
        end
        tick;
        reset = 1'b1;
        if_req[2] = 1'b1; if_addr[2] = 32'h500;
        sample;
        check("t6_if_gnt_rel", if_gnt[2],    1);
        check("t6_rv_t5",      dm_rvalid[2], 0);
        tick;
        if_req[2] = 1'b0;
        for (int j = 6; j <= 7; j++) begin
            sample;
            check("t6_dm_rv_late", dm_rvalid[2], 0);
            check("t6_if_rv_early", if_rvalid[2], 0);
            tick;
        end
        sample;
        check("t6_if_rvalid",  if_rvalid[2], 1);
        check("t6_if_rdata",   if_rdata[2],  mem_fn(32'h500));
        check("t6_dm_rv_t8",   dm_rvalid[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the processor's fetch stage (IF) and load/store stage (DM).
- Grants one requester per issue slot and tracks the single outstanding access for MEM_LAT cycles.
- Routes the read data back to the owning requester.
- Data side has priority; a bounded-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from issue to memory read data valid (legal range 1..7)
- IF_STARVE_MAX, 4, consecutive DM grants allowed while IF waits (legal range 1..7)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request issued this cycle
- if_rvalid  out  1  fetch data valid on if_rdata
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request; held with all dm_* fields stable until dm_gnt
- dm_we  in  1  1 = write
- dm_be  in  DATA_W/8  byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request issued this cycle
- dm_rvalid  out  1  data read data valid, or write acknowledge
- dm_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- Reset (reset low, asynchronous):
  - Outstanding state cleared; latency counter = 0; starvation counter = 0.
  - All outputs are gated to 0 while reset is low, including the combinational grant outputs.
- States:
  - IDLE: nothing outstanding.
  - BUSY: one access outstanding; owner bit stored (0 = IF, 1 = DM); latency counter cnt.
- Issue:
  - At most one issue per cycle, allowed only when a slot is free: state is IDLE, or BUSY and the outstanding access completes this cycle.
  - If a slot is free and any request is present, exactly one gnt is asserted combinationally in that cycle.
  - mem_en = if_gnt | dm_gnt.
  - mem_* fields are muxed from the granted requester; when neither is granted they are 0.
  - For an IF grant: mem_we = 0 and mem_be = all ones.
- Arbitration when both request:
  - DM wins unless starve_cnt == IF_STARVE_MAX, in which case IF wins.
  - starve_cnt increments on each DM grant while if_req = 1, and saturates at IF_STARVE_MAX.
  - starve_cnt clears on any IF grant.
  - A sole requester always wins.
- Completion:
  - Issue at cycle T sets cnt = MEM_LAT and state BUSY.
  - cnt decrements each cycle.
  - Completion happens in the cycle where cnt == 1, i.e. cycle T + MEM_LAT.
  - In that cycle the owner's rvalid = 1 for exactly one cycle, and its rdata = mem_rdata.
  - The non-owner rdata = 0. Writes also produce the one-cycle rvalid as an acknowledge; rdata is don't-care.
- Throughput:
  - Back-to-back issue is permitted on the completion cycle.
  - With MEM_LAT = 1, one access per cycle is sustained; otherwise one per MEM_LAT cycles.
- The arbiter never issues a second access while one is outstanding and not completing.
- Reset asserted mid-access: the access is abandoned; no rvalid is ever produced for it after reset release.
- A request dropped before its grant is a protocol violation; behaviour is unspecified, and the bench asserts it never happens.

Test Plan:
1. Reset held low with if_req = dm_req = 1 -> every output 0. Release -> IF/DM arbitration begins that cycle; dm_gnt = 1 first.
2. MEM_LAT = 2, single IF read of addr 0x40, memory returns 0xDEADBEEF -> if_gnt and mem_en at T with mem_addr = 0x40, mem_we = 0; if_rvalid = 1 with if_rdata = 0xDEADBEEF at T+2 only; dm_rvalid stays 0.
3. MEM_LAT = 2, DM write to addr 0x100, wdata 0x12345678, be 4'b0011 -> mem_we = 1, mem_be = 4'b0011, mem_wdata = 0x12345678 at T; dm_rvalid pulse at T+2.
4. Both requesting continuously, IF_STARVE_MAX = 4 -> grant sequence DM, DM, DM, DM, IF, DM, DM, DM, DM, IF, ...; never two issues within MEM_LAT cycles.
5. MEM_LAT = 1, IF requesting 8 consecutive addresses -> 8 grants in 8 consecutive cycles; each rvalid one cycle after its grant, in order.
6. MEM_LAT = 3, reset asserted at T+1 after a DM read issue, released at T+5 -> no dm_rvalid at T+3 or later; the next request is granted immediately on release.
